// File: rtl/des_match_collector_pkg.sv
// des_match_collector_pkg
//   Shared constants for the DES match collector: hash width, default tag
//   width, drop counter width and the saturating drop-count helper.
package des_match_collector_pkg;

  localparam int HASH_W        = 64;
  localparam int TAG_W_DEFAULT = 68;
  localparam int DROP_W        = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

  // Increment a drop count, holding at the maximum instead of wrapping.
  function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] cnt);
    if (cnt == DROP_MAX) begin
      return DROP_MAX;
    end else begin
      return cnt + 8'd1;
    end
  endfunction

endpackage

// File: rtl/des_match_collector_if.sv
// des_match_collector_if
//   Result-in / match-out bus of the collector.
//   in_valid/in_hash_l/in_hash_r/in_tag : DES pipeline result (no backpressure)
//   out_valid/out_tag/out_ready         : valid/ready stream of matched tags
//   master : pipeline + consumer side, slave : collector side
interface des_match_collector_if
  import des_match_collector_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
);

  logic                  in_valid;
  logic [HASH_W/2-1:0]   in_hash_l;
  logic [HASH_W/2-1:0]   in_hash_r;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_ready;

  modport master (
    output in_valid, in_hash_l, in_hash_r, in_tag, out_ready,
    input  out_valid, out_tag
  );

  modport slave (
    input  in_valid, in_hash_l, in_hash_r, in_tag, out_ready,
    output out_valid, out_tag
  );

endinterface

// File: rtl/des_match_collector_match_fifo.sv
// match_fifo
//   Synchronous FIFO of DEPTH (power of two) entries of width W.
//   push/din : write request; refused when full unless a pop happens too
//   pop      : read request; ignored when empty
//   dout     : head entry, read combinationally from storage
//   count    : occupancy 0..DEPTH, valid : count != 0, full : count == DEPTH
module match_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 68
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_nxt_s;
  logic          valid_r;
  logic          full_s;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign full_s    = (count_r == FULL_CNT);
  assign pop_ok_s  = pop & valid_r;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok_s = push & (~full_s | pop_ok_s);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + ONE_CNT;
      2'b01:   count_nxt_s = count_r - ONE_CNT;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered non-empty flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {(AW+1){1'b0}});
    end
  end

  // Entry storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign valid = valid_r;
  assign full  = full_s;

endmodule

// File: rtl/des_match_collector.sv
// des_match_collector
//   Compares each DES pipeline result against TARGET, queues the tags of
//   matching results and hands them out on a valid/ready stream.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : result input and tag output (des_match_collector_if.slave)
//   target   : {L,R} hash to look for, quasi-static
//   clr      : synchronous clear of overflow and drop_cnt
//   count    : FIFO occupancy, overflow : sticky drop flag,
//   drop_cnt : dropped matches, saturating
module des_match_collector
  import des_match_collector_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  des_match_collector_if.slave     bus,
  input  logic [HASH_W-1:0]        target,
  input  logic                     clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  logic              s1_valid_r;
  logic              s1_match_r;
  logic [TAG_W-1:0]  s1_tag_r;
  logic              match_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic              fifo_valid_s;
  logic              fifo_full_s;
  logic              overflow_r;
  logic [DROP_W-1:0] drop_cnt_r;

  assign match_s = ({bus.in_hash_l, bus.in_hash_r} == target);

  // Stage 1: register the result qualifier, its tag and the compare outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_match_r <= 1'b0;
      s1_tag_r   <= {TAG_W{1'b0}};
    end else begin
      s1_valid_r <= bus.in_valid;
      s1_match_r <= match_s;
      s1_tag_r   <= bus.in_tag;
    end
  end

  assign push_s = s1_valid_r & s1_match_r;
  assign pop_s  = fifo_valid_s & bus.out_ready;
  // Lost only when full and the consumer does not free a slot this edge.
  assign drop_s = push_s & fifo_full_s & ~pop_s;

  match_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (s1_tag_r),
    .pop   (pop_s),
    .dout  (bus.out_tag),
    .count (count),
    .valid (fifo_valid_s),
    .full  (fifo_full_s)
  );

  // Sticky overflow and saturating drop count; a drop beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {DROP_W{1'b0}};
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      drop_cnt_r <= clr ? {{(DROP_W-1){1'b0}}, 1'b1} : drop_sat_inc(drop_cnt_r);
    end else if (clr) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {DROP_W{1'b0}};
    end else begin
      overflow_r <= overflow_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign bus.out_valid = fifo_valid_s;
  assign overflow      = overflow_r;
  assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_des_match_collector.sv
// tb_des_match_collector
//   Directed and randomized stimulus for des_match_collector, checked against
//   a queue-based reference model of the collector's behaviour.
module tb_des_match_collector;
  import des_match_collector_pkg::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 68;

  logic              clk = 1'b0;
  logic              rst;
  logic [63:0]       target;
  logic              clr;
  logic [3:0]        count;
  logic              overflow;
  logic [7:0]        drop_cnt;

  des_match_collector_if #(.TAG_W(TAG_W)) bus ();

  des_match_collector #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .target   (target),
    .clr      (clr),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of waiting tags, one result in flight, flags.
  logic [TAG_W-1:0] mq[$];
  logic             m_pend;
  logic [TAG_W-1:0] m_pend_tag;
  logic             m_ovf;
  int               m_drop;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_model(input string name);
    chk({name, "/out_valid"}, 128'(bus.out_valid), 128'(mq.size() != 0));
    chk({name, "/count"},     128'(count),         128'(mq.size()));
    if (mq.size() != 0) chk({name, "/out_tag"}, 128'(bus.out_tag), 128'(mq[0]));
    chk({name, "/overflow"},  128'(overflow),      128'(m_ovf));
    chk({name, "/drop_cnt"},  128'(drop_cnt),      128'(m_drop));
  endtask

  function automatic logic [63:0] miss_hash();
    logic [63:0] x;
    x = {$urandom, $urandom};
    if (x == 64'd0) x = 64'd1;
    return target ^ x;
  endfunction

  function automatic logic [TAG_W-1:0] rand_tag();
    return TAG_W'({$urandom, $urandom, $urandom});
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input logic v, input logic [63:0] hash, input logic [TAG_W-1:0] tag,
                      input logic rdy, input logic c, input string name);
    logic drop;
    bus.in_valid  = v;
    bus.in_hash_l = hash[63:32];
    bus.in_hash_r = hash[31:0];
    bus.in_tag    = tag;
    bus.out_ready = rdy;
    clr           = c;
    @(posedge clk);
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    drop = 1'b0;
    if (m_pend) begin
      if (mq.size() < DEPTH) mq.push_back(m_pend_tag);
      else drop = 1'b1;
    end
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = c ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (c) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    m_pend     = v && (hash == target);
    m_pend_tag = tag;
    #1;
    check_model(name);
  endtask

  task automatic idle(input logic rdy, input string name);
    step(1'b0, miss_hash(), rand_tag(), rdy, 1'b0, name);
  endtask

  task automatic match(input logic [TAG_W-1:0] tag, input logic rdy, input string name);
    step(1'b1, target, tag, rdy, 1'b0, name);
  endtask

  // Assert reset mid-cycle, check its immediate effect, release after two edges.
  task automatic apply_reset(input string name);
    rst = 1'b1;
    #1;
    chk({name, "/rst_out_valid"}, 128'(bus.out_valid), 128'(0));
    chk({name, "/rst_count"},     128'(count),         128'(0));
    chk({name, "/rst_overflow"},  128'(overflow),      128'(0));
    chk({name, "/rst_drop_cnt"},  128'(drop_cnt),      128'(0));
    mq.delete();
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    clr           = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    target        = 64'h0123456789ABCDEF;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_hash_l = 32'd0;
    bus.in_hash_r = 32'd0;
    bus.in_tag    = {TAG_W{1'b0}};
    bus.out_ready = 1'b0;
    #2;
    apply_reset("reset");

    // Single match: visible two cycles after it is presented.
    match(68'h5, 1'b0, "single_in");
    chk("single_lat1_valid", 128'(bus.out_valid), 128'(0));
    idle(1'b0, "single_lat1");
    idle(1'b0, "single_lat2");
    chk("single_valid", 128'(bus.out_valid), 128'(1));
    chk("single_tag",   128'(bus.out_tag),   128'(68'h5));
    chk("single_count", 128'(count),         128'(1));
    idle(1'b1, "single_pop");
    idle(1'b1, "ready_when_empty");

    // Non-matching valid results never enter the FIFO.
    for (int i = 0; i < 100; i++) step(1'b1, miss_hash(), rand_tag(), 1'b0, 1'b0, "nomatch");
    idle(1'b0, "nomatch_end");
    chk("nomatch_count",    128'(count),    128'(0));
    chk("nomatch_overflow", 128'(overflow), 128'(0));

    // Ten matches into a stalled FIFO: two dropped, first eight kept in order.
    for (int i = 1; i <= 10; i++) match(TAG_W'(i), 1'b0, "fill10");
    idle(1'b0, "fill10_end");
    chk("fill10_count",    128'(count),    128'(8));
    chk("fill10_drop",     128'(drop_cnt), 128'(2));
    chk("fill10_overflow", 128'(overflow), 128'(1));
    for (int i = 1; i <= 8; i++) begin
      chk("drain10_order", 128'(bus.out_tag), 128'(i));
      idle(1'b1, "drain10");
    end

    // Full FIFO with a pop on the push edge: accepted, nothing dropped.
    for (int i = 0; i < 8; i++) match(TAG_W'(32 + i), 1'b0, "fill8");
    idle(1'b0, "fill8_end");
    match(68'h99, 1'b0, "full_match");
    idle(1'b1, "full_pushpop");
    chk("full_pushpop_count", 128'(count),    128'(8));
    chk("full_pushpop_drop",  128'(drop_cnt), 128'(2));
    for (int i = 0; i < 7; i++) idle(1'b1, "full_drain");
    chk("full_last_tag", 128'(bus.out_tag), 128'(68'h99));
    idle(1'b1, "full_drain_last");

    // Drop counter saturation, clear, and drop-beats-clear.
    for (int i = 0; i < 8; i++) match(rand_tag(), 1'b0, "sat_fill");
    for (int i = 0; i < 300; i++) match(rand_tag(), 1'b0, "sat_drops");
    idle(1'b0, "sat_end");
    chk("sat_drop", 128'(drop_cnt), 128'(255));
    step(1'b0, miss_hash(), rand_tag(), 1'b0, 1'b1, "clr_pulse");
    chk("clr_drop",     128'(drop_cnt), 128'(0));
    chk("clr_overflow", 128'(overflow), 128'(0));
    match(rand_tag(), 1'b0, "clr_drop_in");
    step(1'b0, miss_hash(), rand_tag(), 1'b0, 1'b1, "clr_with_drop");
    chk("clr_with_drop_ovf",  128'(overflow), 128'(1));
    chk("clr_with_drop_drop", 128'(drop_cnt), 128'(1));
    for (int i = 0; i < 9; i++) idle(1'b1, "sat_drain");

    // Randomized traffic, including occasional target changes and clears.
    for (int i = 0; i < 600; i++) begin
      logic v, m, r, c;
      if ($urandom_range(0, 60) == 0) target = {$urandom, $urandom};
      v = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 1) == 0);
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 40) == 0);
      step(v, m ? target : miss_hash(), rand_tag(), r, c, "random");
    end
    for (int i = 0; i < 10; i++) idle(1'b1, "random_drain");

    // Reset mid-stream with five queued and a match in stage 1.
    for (int i = 0; i < 5; i++) match(TAG_W'(64 + i), 1'b0, "rst_fill");
    idle(1'b0, "rst_fill_end");
    chk("rst_pre_count", 128'(count), 128'(5));
    match(68'hABC, 1'b0, "rst_stage1");
    apply_reset("midstream");
    for (int i = 0; i < 3; i++) idle(1'b1, "post_rst_idle");
    chk("post_rst_count", 128'(count), 128'(0));
    match(68'h77, 1'b0, "post_rst_match");
    idle(1'b0, "post_rst_lat1");
    idle(1'b0, "post_rst_lat2");
    chk("post_rst_tag", 128'(bus.out_tag), 128'(68'h77));
    idle(1'b1, "post_rst_pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
